// File: rtl/sdram_pkg.sv
// Shared command-bus encoding for the SDRAM responder and its controller.
// Holds opcodes, cmd field positions, init-state encoding and err bit indices.
package sdram_pkg;
  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;

  localparam int CMD_CKE   = 7;
  localparam int CMD_CS_N  = 6;
  localparam int CMD_OP_HI = 5;
  localparam int CMD_OP_LO = 3;
  localparam int CMD_BA_HI = 2;
  localparam int CMD_BA_LO = 1;
  localparam int CMD_A10   = 0;

  typedef enum logic [2:0] {
    INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, INIT_READY
  } init_state_e;

  localparam int ERR_INIT    = 0;
  localparam int ERR_TIMING  = 1;
  localparam int ERR_STATE   = 2;
  localparam int ERR_REFRESH = 3;

  localparam int TMR_W = 8;

  // A timer loaded with t-1 lets the next command through exactly t edges later.
  function automatic logic [TMR_W-1:0] tmr_load(input int t);
    return (t > 0) ? TMR_W'(t - 1) : '0;
  endfunction
endpackage

// File: rtl/sdram_bank_track.sv
// One bank's open/row state plus its activate/precharge timing window.
module sdram_bank_track
  import sdram_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int T_RP  = 2,
  parameter int T_RCD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act_i,
  input  logic             close_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             open_o,
  output logic             busy_o,
  output logic             legal_rw_o,
  output logic             legal_act_o,
  output logic [ROW_W-1:0] row_o
);
  logic             open_q, open_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    tmr_d  = (tmr_q == '0) ? '0 : tmr_q - TMR_W'(1);
    if (act_i) begin
      open_d = 1'b1;
      row_d  = row_i;
      tmr_d  = tmr_load(T_RCD);
    end else if (close_i) begin
      open_d = 1'b0;
      tmr_d  = tmr_load(T_RP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= 1'b0;
      row_q  <= '0;
      tmr_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      tmr_q  <= tmr_d;
    end
  end

  assign open_o      = open_q;
  assign row_o       = row_q;
  assign busy_o      = (tmr_q != '0);
  assign legal_rw_o  = open_q & ~busy_o;
  assign legal_act_o = ~open_q & ~busy_o;
endmodule

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes the command bus, checks init/timing/state
// rules and serves reads after CAS latency. SDRAM_REFRESH_CHECK_EN adds the refresh-interval check.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_W       = 4,
  parameter int COL_W       = 4,
  parameter int DATA_W      = 16,
  parameter int T_RP        = 2,
  parameter int T_RCD       = 2,
  parameter int T_RFC       = 8,
  parameter int T_MRD       = 2,
  parameter int REFRESH_MAX = 520,
  localparam int RC_MAX     = (ROW_W > COL_W) ? ROW_W : COL_W,
  localparam int ADDR_W     = (RC_MAX > 7) ? RC_MAX : 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ready,
  output logic [3:0]        bank_open,
  output logic [3:0]        err
);
  localparam int MEM_AW = 2 + ROW_W + COL_W;

  logic       sel, a10, cl_ok, glob_busy, exp_ok, go;
  logic [2:0] op, mode_cl;
  logic [1:0] ba;
  assign sel       = cmd[CMD_CKE] & ~cmd[CMD_CS_N];
  assign op        = cmd[CMD_OP_HI:CMD_OP_LO];
  assign ba        = cmd[CMD_BA_HI:CMD_BA_LO];
  assign a10       = cmd[CMD_A10];
  assign mode_cl   = addr[6:4];
  assign cl_ok     = (mode_cl == 3'd2) || (mode_cl == 3'd3);

  logic [3:0]            b_open, b_busy, b_rw, b_act, act_v, close_v;
  logic [3:0][ROW_W-1:0] b_row;

  for (genvar g = 0; g < 4; g++) begin : g_bank
    sdram_bank_track #(.ROW_W(ROW_W), .T_RP(T_RP), .T_RCD(T_RCD)) u_bank (
      .clk(CLK), .rst(RESET), .act_i(act_v[g]), .close_i(close_v[g]),
      .row_i(addr[ROW_W-1:0]), .open_o(b_open[g]), .busy_o(b_busy[g]),
      .legal_rw_o(b_rw[g]), .legal_act_o(b_act[g]), .row_o(b_row[g])
    );
  end

  init_state_e              init_q, init_d;
  logic                     ready_q, ready_d, rdata_valid_q, rdata_valid_d;
  logic                     wr_go, rd_go, ref_go, refresh_late;
  logic [2:0]               cl_q, cl_d;
  logic [TMR_W-1:0]         glob_q, glob_d;
  logic [3:0]               err_q, err_d, err_v;
  logic [3:1]               vld_pipe_q, vld_pipe_d;
  logic [3:1][DATA_W-1:0]   dat_pipe_q, dat_pipe_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d, rd_word;
  logic [MEM_AW-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem [2**MEM_AW];

  assign glob_busy = (glob_q != '0);
  assign mem_addr  = {ba, b_row[ba], addr[COL_W-1:0]};
  assign rd_word   = mem[mem_addr];

  always_comb begin
    init_d  = init_q;
    ready_d = ready_q;
    cl_d    = cl_q;
    glob_d  = glob_busy ? glob_q - TMR_W'(1) : '0;
    err_v   = '0;
    exp_ok  = 1'b0;
    go      = 1'b0;
    act_v   = '0;
    close_v = '0;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    ref_go  = 1'b0;
    if (sel && op != CMD_NOP && op != CMD_BST) begin
      if (!ready_q) begin
        unique case (init_q)
          INIT_PRE:             exp_ok = (op == CMD_PRE) && a10;
          INIT_REF1, INIT_REF2: exp_ok = (op == CMD_REF);
          INIT_MRS:             exp_ok = (op == CMD_MRS);
          default:              exp_ok = 1'b0;
        endcase
        err_v[ERR_INIT]   = ~exp_ok | ((op == CMD_MRS) & ~cl_ok);
        err_v[ERR_TIMING] = exp_ok & glob_busy;
        go = (err_v == '0);
      end else begin
        unique case (op)
          CMD_ACT: begin
            err_v[ERR_TIMING] = glob_busy | b_busy[ba];
            err_v[ERR_STATE]  = b_open[ba];
            go = ~glob_busy & b_act[ba];
          end
          CMD_RD, CMD_WR: begin
            err_v[ERR_TIMING] = glob_busy | b_busy[ba];
            err_v[ERR_STATE]  = ~b_open[ba];
            go = ~glob_busy & b_rw[ba];
          end
          CMD_REF: begin
            err_v[ERR_TIMING] = glob_busy | (|b_busy);
            err_v[ERR_STATE]  = |b_open;
            go = ~glob_busy & (&b_act);
          end
          CMD_MRS: begin
            err_v[ERR_TIMING] = glob_busy;
            err_v[ERR_INIT]   = ~cl_ok;
            go = ~glob_busy & cl_ok;
          end
          default: begin
            err_v[ERR_TIMING] = glob_busy;
            go = ~glob_busy;
          end
        endcase
      end
    end
    if (go) begin
      unique case (op)
        CMD_ACT: act_v[ba] = 1'b1;
        CMD_RD: begin
          rd_go       = 1'b1;
          close_v[ba] = a10;
        end
        CMD_WR: begin
          wr_go       = 1'b1;
          close_v[ba] = a10;
        end
        // Banks are already idle out of reset, so the init precharge only advances the FSM.
        CMD_PRE: begin
          if (ready_q) close_v = a10 ? 4'hf : (4'b0001 << ba);
          else         init_d  = INIT_REF1;
        end
        CMD_REF: begin
          ref_go = 1'b1;
          glob_d = tmr_load(T_RFC);
          if (!ready_q) init_d = (init_q == INIT_REF1) ? INIT_REF2 : INIT_MRS;
        end
        CMD_MRS: begin
          cl_d    = mode_cl;
          glob_d  = tmr_load(T_MRD);
          init_d  = INIT_READY;
          ready_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Each read enters the pipe at the slot matching the latency in force when it was issued.
  always_comb begin
    vld_pipe_d = {1'b0, vld_pipe_q[3:2]};
    dat_pipe_d = {DATA_W'(0), dat_pipe_q[3:2]};
    if (rd_go) begin
      if (cl_q == 3'd2) begin
        vld_pipe_d[2] = 1'b1;
        dat_pipe_d[2] = rd_word;
      end else begin
        vld_pipe_d[3] = 1'b1;
        dat_pipe_d[3] = rd_word;
      end
    end
    rdata_valid_d = vld_pipe_q[1];
    rdata_d       = vld_pipe_q[1] ? dat_pipe_q[1] : rdata_q;
  end

`ifdef SDRAM_REFRESH_CHECK_EN
  localparam int RC_W = $clog2(REFRESH_MAX + 2);
  logic [RC_W-1:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (!ready_q || ref_go)                  rcnt_d = '0;
    else if (rcnt_q <= RC_W'(REFRESH_MAX))   rcnt_d = rcnt_q + RC_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end

  assign refresh_late = ready_q && (rcnt_d > RC_W'(REFRESH_MAX));
`else
  logic unused_refresh_max;
  assign unused_refresh_max = (REFRESH_MAX != 0);
  assign refresh_late       = 1'b0;
`endif

  always_comb begin
    err_d = err_q | err_v;
    err_d[ERR_REFRESH] = err_q[ERR_REFRESH] | refresh_late;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      init_q        <= INIT_PRE;
      ready_q       <= 1'b0;
      cl_q          <= 3'd3;
      glob_q        <= '0;
      err_q         <= '0;
      vld_pipe_q    <= '0;
      dat_pipe_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      init_q        <= init_d;
      ready_q       <= ready_d;
      cl_q          <= cl_d;
      glob_q        <= glob_d;
      err_q         <= err_d;
      vld_pipe_q    <= vld_pipe_d;
      dat_pipe_q    <= dat_pipe_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Storage deliberately survives reset.
  always_ff @(posedge CLK) begin
    if (wr_go) mem[mem_addr] <= wdata;
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign ready       = ready_q;
  assign bank_open   = b_open;
  assign err         = err_q;
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Cycle-accurate SDRAM device-side model that sits at the far end of the controller's command bus.
- Decodes the controller's 8-bit command word and tracks the init sequence, per-bank open rows and timing windows.
- Stores write data in an internal array and returns read data after the programmed CAS latency.
- Flags protocol and timing violations on sticky error outputs; used as the memory target in controller-level simulation and FPGA loopback tests.

Parameters:
ROW_W, 4, row address bits per bank
COL_W, 4, column address bits
DATA_W, 16, data word width
T_RP, 2, precharge-to-activate/refresh cycles
T_RCD, 2, activate-to-read/write cycles
T_RFC, 8, refresh-to-any-command cycles
T_MRD, 2, load-mode-to-any-command cycles
REFRESH_MAX, 520, max cycles between refreshes (optional feature only)

Ports:
CLK  in  1  clock
RESET  in  1  reset, asynchronous, active-high
cmd  in  8  {cke, cs_n, ras_n, cas_n, we_n, ba[1:0], a10}
addr  in  max(ROW_W,COL_W,7)  row on ACTIVATE, column on READ/WRITE, mode on LOAD MODE
wdata  in  DATA_W  write data, sampled with the WRITE command
rdata  out  DATA_W  read data
rdata_valid  out  1  rdata qualifier, one cycle per READ
ready  out  1  init sequence complete
bank_open  out  4  per-bank row-open status
err  out  4  sticky violation flags

Behaviour:
- Reset (async, active-high): rdata=0, rdata_valid=0, ready=0, bank_open=0, err=0, CL=3, all timers 0, init FSM=INIT_PRE, read pipe cleared. Memory contents are not reset.
- Decode happens only when cke=1 and cs_n=0; otherwise the cycle is a NOP.
- {ras_n,cas_n,we_n}: 011 ACTIVATE, 101 READ, 100 WRITE, 010 PRECHARGE (a10=1: all banks), 001 AUTO-REFRESH, 000 LOAD MODE, 111 NOP.
- Init FSM:
  - INIT_PRE: PRECHARGE-all -> INIT_REF1.
  - INIT_REF1: AUTO-REFRESH -> INIT_REF2.
  - INIT_REF2: AUTO-REFRESH -> INIT_MRS.
  - INIT_MRS: LOAD MODE -> READY.
  - Any other non-NOP command before READY sets err[0]; state is unchanged.
  - ready=1 from the edge following the LOAD MODE command.
- LOAD MODE: CL=addr[6:4]. Legal values are 2 or 3; any other value sets err[0] and CL keeps its previous value.
- Global timer: loaded with T_RFC on AUTO-REFRESH and T_MRD on LOAD MODE. While the global timer is nonzero, every non-NOP command is a violation.
- Per-bank state is IDLE or ACTIVE(row), with a per-bank timer:
  - ACTIVATE on an IDLE bank: opens the row and loads T_RCD.
  - PRECHARGE: closes the bank(s) and loads T_RP.
  - READ/WRITE with a10=1: auto-precharge; the bank closes at the same edge and loads T_RP.
- Violations: command issued while the relevant timer is nonzero sets err[1]. READ/WRITE to an IDLE bank, ACTIVATE to an ACTIVE bank, or AUTO-REFRESH with any bank open sets err[2].
- A violating command is ignored entirely: no state change, no memory write, no read issued.
- WRITE sampled at edge t commits mem[ba][row][col] at edge t. A READ at t+1 to the same address returns the new data.
- READ sampled at edge t: rdata/rdata_valid are registered at edge t+CL and valid for one cycle.
- Reads at t and t+1 produce back-to-back valid cycles.
- A CL change affects only reads issued after the LOAD MODE command; in-flight reads keep their latency.
- Timers saturate at 0. All err bits are sticky until RESET.
- Reset mid-operation aborts in-flight reads (rdata_valid=0 immediately, asynchronously) and returns the block to INIT_PRE.

Optional Feature:
SDRAM_REFRESH_CHECK_EN
- Defined:
  - A counter starts at READY and clears on each AUTO-REFRESH.
  - When the count exceeds REFRESH_MAX, err[3] is set (sticky).
  - The counter saturates.
- Undefined: the counter is not built and err[3] is tied to 0.

Decomposition:
- sdram_pkg holds:
  - command opcode localparams (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS);
  - cmd field bit positions;
  - the init-state encoding;
  - err bit indices.
  The controller shares this package.
- One sub-module, sdram_bank_track, instantiated 4x. It holds open/row/timer for one bank and outputs legal_rw and legal_act.

Test Plan:
- Full init (PRE-all, REF, 8 NOPs, REF, 8 NOPs, MRS addr[6:4]=2, 2 NOPs) -> ready=1 on the edge after MRS, err=0.
- ACT bank1 row5, 2 NOPs, WRITE col3 wdata=0xBEEF a10=0, READ col3 a10=1 at CL=2 -> rdata=0xBEEF, rdata_valid exactly 2 edges after the READ; bank_open[1]=0 after the READ.
- READ issued 1 cycle after ACT (T_RCD=2) -> err[1]=1, rdata_valid never asserts, and a following legal read returns the old data.
- ACTIVATE before init completes -> err[0]=1, ready stays 0; READ to an idle bank after init -> err[2]=1.
- MRS CL=3, two reads back-to-back to addresses holding 0x1111/0x2222 -> valid on edges t+3 and t+4 with the data in order; assert RESET at t+2 -> rdata_valid=0, no data emerges.
- With SDRAM_REFRESH_CHECK_EN: 521 NOP cycles after ready -> err[3]=1; with a refresh at cycle 500 -> err[3] stays 0.
